// File: rtl/rx_pkg.sv
// Shared encodings for the PCIe RX path: datapath load commands, TLP kinds,
// receive FSM states and the OCP burst-sequence codes used by the datapath.
package rx_pkg;

    typedef enum logic [2:0] {
        CTL_IDLE  = 3'b000,
        CTL_H1    = 3'b001,
        CTL_H2    = 3'b010,
        CTL_DATA3 = 3'b011,
        CTL_DATA4 = 3'b100
    } reg_ctl_e;

    typedef enum logic [1:0] {
        OP_MRD  = 2'b00,
        OP_MWR  = 2'b01,
        OP_UNS2 = 2'b10,
        OP_UNS3 = 2'b11
    } optype_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR1    = 3'd1,
        ST_HDR2    = 3'd2,
        ST_WR_DATA = 3'd3,
        ST_WR_LAST = 3'd4,
        ST_RD_REQ  = 3'd5,
        ST_DROP    = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        BSEQ_INCR  = 3'b000,
        BSEQ_DFLT1 = 3'b001,
        BSEQ_WRAP  = 3'b010,
        BSEQ_DFLT2 = 3'b011,
        BSEQ_XOR   = 3'b100,
        BSEQ_STRM  = 3'b101,
        BSEQ_UNKN  = 3'b110,
        BSEQ_BLCK  = 3'b111
    } burst_seq_e;

endpackage

// File: rtl/rx_tlp_fsm_if.sv
// Handshake bundle between the PCIe RX AXI-stream, the completion-header
// FIFO, the OCP master and the receive control FSM.
interface rx_tlp_fsm_if #(
    parameter int keep_width = 8
);
    logic                  rx_valid;
    logic [keep_width-1:0] rx_keep;
    logic                  rx_last;
    logic                  rx_ready;
    logic                  tx_header_fifo_ready;
    logic                  tx_header_fifo_valid;
    logic                  ocp_ready;
    logic [1:0]            optype;
    logic [2:0]            ocp_reg_ctl;
    logic                  read_request;
    logic                  write_request;

    // Environment side: PCIe core, header FIFO, OCP slave and datapath decode
    modport master (
        output rx_valid, rx_keep, rx_last, tx_header_fifo_ready, ocp_ready, optype,
        input  rx_ready, tx_header_fifo_valid, ocp_reg_ctl, read_request, write_request
    );

    modport slave (
        input  rx_valid, rx_keep, rx_last, tx_header_fifo_ready, ocp_ready, optype,
        output rx_ready, tx_header_fifo_valid, ocp_reg_ctl, read_request, write_request
    );
endinterface

// File: rtl/rx_tlp_fsm.sv
// Receive-path control FSM: steps 3-DW MRd/MWr TLP beats into the datapath
// registers, paces rx_ready and issues OCP read/write requests.
module rx_tlp_fsm
    import rx_pkg::*;
(
    input  logic        rx_clk,
    input  logic        rx_reset,
    rx_tlp_fsm_if.slave bus
);

    state_e   r_state;
    optype_e  r_op_q;
    logic     r_rd_done;
    logic     r_hdr_done;

    logic     w_rx_ready;
    logic     w_hdr_valid;
    logic     w_rd_req;
    logic     w_wr_req;
    reg_ctl_e w_ctl;
    logic     w_accept;
    logic     w_rd_fin;
    logic     w_hdr_fin;

    // Outputs are combinational so handshakes see zero latency; rx_ready never
    // looks at rx_valid.
    always_comb begin
        w_rx_ready  = 1'b0;
        w_ctl       = CTL_IDLE;
        w_rd_req    = 1'b0;
        w_wr_req    = 1'b0;
        w_hdr_valid = 1'b0;
        case (r_state)
            ST_HDR1: begin
                w_rx_ready = 1'b1;
                w_ctl      = CTL_H1;
            end
            ST_HDR2: begin
                w_rx_ready = 1'b1;
                w_ctl      = CTL_H2;
            end
            ST_WR_DATA: begin
                w_rx_ready = bus.ocp_ready;
                w_ctl      = (bus.rx_valid && bus.rx_last) ? CTL_DATA4 : CTL_DATA3;
                w_wr_req   = bus.rx_valid & bus.ocp_ready;
            end
            ST_WR_LAST: begin
                w_wr_req = 1'b1;
            end
            ST_RD_REQ: begin
                w_rd_req    = ~r_rd_done;
                w_hdr_valid = ~r_hdr_done;
            end
            ST_DROP: begin
                w_rx_ready = 1'b1;
            end
            default: ;
        endcase
        if (rx_reset) begin
            w_rx_ready  = 1'b0;
            w_ctl       = CTL_IDLE;
            w_rd_req    = 1'b0;
            w_wr_req    = 1'b0;
            w_hdr_valid = 1'b0;
        end
    end

    assign w_accept  = bus.rx_valid & w_rx_ready;
    assign w_rd_fin  = r_rd_done  | bus.ocp_ready;
    assign w_hdr_fin = r_hdr_done | bus.tx_header_fifo_ready;

    always_ff @(posedge rx_clk) begin
        if (rx_reset) begin
            r_state    <= ST_IDLE;
            r_op_q     <= OP_MRD;
            r_rd_done  <= 1'b0;
            r_hdr_done <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= ST_HDR1;
                ST_HDR1: begin
                    if (w_accept) begin
                        r_op_q <= optype_e'(bus.optype);
                        if (bus.rx_last)
                            r_state <= ST_HDR1;
                        else if (!(&bus.rx_keep))
                            r_state <= ST_DROP;
                        else
                            r_state <= ST_HDR2;
                    end
                end
                // Decision uses the kind latched from DW0 on the first header beat
                ST_HDR2: begin
                    if (w_accept) begin
                        case (r_op_q)
                            OP_MRD:  r_state <= bus.rx_last ? ST_RD_REQ  : ST_DROP;
                            OP_MWR:  r_state <= bus.rx_last ? ST_WR_LAST : ST_WR_DATA;
                            default: r_state <= bus.rx_last ? ST_HDR1    : ST_DROP;
                        endcase
                    end
                end
                ST_WR_DATA: begin
                    if (w_accept && bus.rx_last)
                        r_state <= ST_WR_LAST;
                end
                ST_WR_LAST: begin
                    if (bus.ocp_ready)
                        r_state <= ST_HDR1;
                end
                ST_RD_REQ: begin
                    if (w_rd_fin && w_hdr_fin) begin
                        r_state    <= ST_HDR1;
                        r_rd_done  <= 1'b0;
                        r_hdr_done <= 1'b0;
                    end else begin
                        r_rd_done  <= w_rd_fin;
                        r_hdr_done <= w_hdr_fin;
                    end
                end
                ST_DROP: begin
                    if (w_accept && bus.rx_last)
                        r_state <= ST_HDR1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rx_ready             = w_rx_ready;
    assign bus.ocp_reg_ctl          = w_ctl;
    assign bus.read_request         = w_rd_req;
    assign bus.write_request        = w_wr_req;
    assign bus.tx_header_fifo_valid = w_hdr_valid;

endmodule

// File: tb/tb_rx_tlp_fsm.sv
// Bench for rx_tlp_fsm: directed TLP scenarios followed by random traffic,
// every cycle compared against a TLP-progress reference model.
module tb_rx_tlp_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rx_tlp_fsm_if #(.keep_width(8)) bus ();

    rx_tlp_fsm dut (
        .rx_clk   (clk),
        .rx_reset (rst),
        .bus      (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int rr_cnt = 0;
    int hv_cnt = 0;
    int wr_cnt = 0;

    // Reference model: where are we inside the current TLP?
    bit m_boot      = 1'b1; // the single dead cycle after reset
    int m_hdr_beats = 0;    // header beats taken so far (0 or 1)
    int m_kind      = 0;    // TLP kind taken from DW0
    bit m_drop      = 1'b0; // discarding rest of TLP
    bit m_wr_data   = 1'b0; // streaming write payload
    bit m_flush     = 1'b0; // residual write DW pending on OCP
    bit m_rd        = 1'b0; // waiting on read command and completion header
    bit m_rd_seen   = 1'b0;
    bit m_cpl_seen  = 1'b0;

    task automatic expect_out(output bit rdy, output int ctl, output bit rr,
                              output bit hv, output bit wr);
        rdy = 0; ctl = 0; rr = 0; hv = 0; wr = 0;
        if (rst || m_boot) return;
        if (m_rd) begin
            rr = !m_rd_seen;
            hv = !m_cpl_seen;
        end else if (m_flush) begin
            wr = 1;
        end else if (m_wr_data) begin
            rdy = bus.ocp_ready;
            ctl = (bus.rx_valid && bus.rx_last) ? 4 : 3;
            wr  = bus.rx_valid && bus.ocp_ready;
        end else if (m_drop) begin
            rdy = 1;
        end else begin
            rdy = 1;
            ctl = (m_hdr_beats == 0) ? 1 : 2;
        end
    endtask

    task automatic model_edge(input bit v, input logic [7:0] k, input bit l,
                              input int op, input bit ordy, input bit frdy,
                              input bit r, input bit rdy);
        bit acc;
        acc = v && rdy;
        if (r) begin
            m_boot = 1; m_hdr_beats = 0; m_kind = 0; m_drop = 0; m_wr_data = 0;
            m_flush = 0; m_rd = 0; m_rd_seen = 0; m_cpl_seen = 0;
            return;
        end
        if (m_boot) begin
            m_boot = 0;
            return;
        end
        if (m_rd) begin
            m_rd_seen  = m_rd_seen  || ordy;
            m_cpl_seen = m_cpl_seen || frdy;
            if (m_rd_seen && m_cpl_seen) begin
                m_rd = 0; m_rd_seen = 0; m_cpl_seen = 0;
            end
        end else if (m_flush) begin
            if (ordy) m_flush = 0;
        end else if (m_wr_data) begin
            if (acc && l) begin
                m_wr_data = 0;
                m_flush   = 1;
            end
        end else if (m_drop) begin
            if (acc && l) m_drop = 0;
        end else if (acc) begin
            if (m_hdr_beats == 0) begin
                m_kind = op;
                if (l)               m_hdr_beats = 0;
                else if (k != 8'hFF) m_drop = 1;
                else                 m_hdr_beats = 1;
            end else begin
                m_hdr_beats = 0;
                if (m_kind == 0) begin
                    if (l) m_rd = 1; else m_drop = 1;
                end else if (m_kind == 1) begin
                    if (l) m_flush = 1; else m_wr_data = 1;
                end else if (!l) begin
                    m_drop = 1;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
    endtask

    // One clock cycle: drive, check outputs mid-cycle, then advance the model at the edge
    task automatic cyc(input bit v, input logic [7:0] k, input bit l, input logic [1:0] op,
                       input bit ordy, input bit frdy, input bit r);
        bit e_rdy, e_rr, e_hv, e_wr;
        int e_ctl;
        bus.rx_valid = v; bus.rx_keep = k; bus.rx_last = l; bus.optype = op;
        bus.ocp_ready = ordy; bus.tx_header_fifo_ready = frdy; rst = r;
        #1;
        expect_out(e_rdy, e_ctl, e_rr, e_hv, e_wr);
        check("rx_ready",      32'(bus.rx_ready),             32'(e_rdy));
        check("ocp_reg_ctl",   32'(bus.ocp_reg_ctl),          32'(e_ctl));
        check("read_request",  32'(bus.read_request),         32'(e_rr));
        check("write_request", 32'(bus.write_request),        32'(e_wr));
        check("hdr_fifo_vld",  32'(bus.tx_header_fifo_valid), 32'(e_hv));
        rr_cnt += int'(bus.read_request);
        hv_cnt += int'(bus.tx_header_fifo_valid);
        wr_cnt += int'(bus.write_request);
        @(posedge clk);
        model_edge(v, k, l, int'(op), ordy, frdy, r, e_rdy);
        #1;
    endtask

    initial begin
        // Reset held two cycles, then the IDLE cycle, then HDR1
        cyc(0, 8'hFF, 0, 2'b00, 0, 0, 1);
        cyc(0, 8'hFF, 0, 2'b00, 0, 0, 1);
        cyc(0, 8'hFF, 0, 2'b00, 0, 0, 0);
        cyc(0, 8'hFF, 0, 2'b00, 0, 0, 0);
        #1;
        check("rx_ready_up_after_reset", 32'(bus.rx_ready), 32'd1);

        // MRd: two header beats, OCP stalls 3 cycles, header FIFO ready at once
        cyc(1, 8'hFF, 0, 2'b00, 0, 1, 0);
        cyc(1, 8'hFF, 1, 2'b11, 0, 1, 0);
        rr_cnt = 0; hv_cnt = 0;
        cyc(0, 8'hFF, 0, 2'b00, 0, 1, 0);
        cyc(0, 8'hFF, 0, 2'b00, 0, 1, 0);
        cyc(0, 8'hFF, 0, 2'b00, 0, 1, 0);
        cyc(0, 8'hFF, 0, 2'b00, 1, 1, 0);
        check("mrd_read_cycles", 32'(rr_cnt), 32'd4);
        check("mrd_hdr_cycles",  32'(hv_cnt), 32'd1);
        cyc(0, 8'hFF, 0, 2'b00, 0, 0, 0);

        // MWr 4 DW: last beat first stalled by OCP, then WR_LAST waits one cycle
        cyc(1, 8'hFF, 0, 2'b01, 1, 0, 0);
        cyc(1, 8'hFF, 0, 2'b10, 1, 0, 0);
        wr_cnt = 0;
        cyc(1, 8'hFF, 1, 2'b00, 0, 0, 0);
        cyc(1, 8'hFF, 1, 2'b00, 1, 0, 0);
        cyc(0, 8'hFF, 0, 2'b00, 0, 0, 0);
        cyc(0, 8'hFF, 0, 2'b00, 1, 0, 0);
        check("mwr_write_cycles", 32'(wr_cnt), 32'd3);

        // Unsupported TLP, 5 beats, drained with no requests
        rr_cnt = 0; hv_cnt = 0; wr_cnt = 0;
        cyc(1, 8'hFF, 0, 2'b10, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 8'hFF, 0, 2'b00, 0, 0, 0);
        cyc(1, 8'hFF, 1, 2'b00, 0, 0, 0);
        check("uns_no_requests", 32'(rr_cnt + hv_cnt + wr_cnt), 32'd0);

        // Runt, then bad keep on header beat 1 drained to rx_last
        cyc(1, 8'hFF, 1, 2'b01, 1, 1, 0);
        cyc(1, 8'h0F, 0, 2'b00, 1, 1, 0);
        cyc(1, 8'hFF, 0, 2'b00, 1, 1, 0);
        cyc(1, 8'hFF, 1, 2'b00, 1, 1, 0);
        cyc(0, 8'hFF, 0, 2'b00, 0, 0, 0);

        // Reset during WR_DATA aborts the TLP
        cyc(1, 8'hFF, 0, 2'b01, 1, 0, 0);
        cyc(1, 8'hFF, 0, 2'b00, 1, 0, 0);
        cyc(1, 8'hFF, 0, 2'b00, 1, 0, 0);
        cyc(1, 8'hFF, 0, 2'b00, 1, 0, 1);
        cyc(1, 8'hFF, 0, 2'b00, 1, 0, 0);
        cyc(1, 8'hFF, 1, 2'b00, 1, 0, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 9) < 7),
                ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'hFF,
                ($urandom_range(0, 9) < 3),
                2'($urandom),
                ($urandom_range(0, 9) < 6),
                ($urandom_range(0, 9) < 6),
                ($urandom_range(0, 199) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
